// File: rtl/regfile_pkg.sv
// Shared register-file types: address/data widths and the writeback request record
// used by the write-port arbiter and its pending scoreboard.
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int REG_N  = 32;
  localparam int REG_DW = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the two writeback requesters, decode and the register-file write port.
// The arbiter takes the slave view; stimulus/requesters take the master view.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int DW = REG_DW
) ();

  logic            req_a;
  reg_addr_t       addr_a;
  logic [DW-1:0]   data_a;
  logic            gnt_a;

  logic            req_b;
  reg_addr_t       addr_b;
  logic [DW-1:0]   data_b;
  logic            gnt_b;

  logic            write_enable;
  reg_addr_t       write_address;
  logic [DW-1:0]   data_in;

  logic            reserve_valid;
  reg_addr_t       reserve_addr;
  reg_addr_t       read_address1;
  reg_addr_t       read_address2;
  logic            stall;

  modport master (
    output req_a, addr_a, data_a,
    input  gnt_a,
    output req_b, addr_b, data_b,
    input  gnt_b,
    input  write_enable, write_address, data_in,
    output reserve_valid, reserve_addr, read_address1, read_address2,
    input  stall
  );

  modport slave (
    input  req_a, addr_a, data_a,
    output gnt_a,
    input  req_b, addr_b, data_b,
    output gnt_b,
    output write_enable, write_address, data_in,
    input  reserve_valid, reserve_addr, read_address1, read_address2,
    output stall
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for read-after-write hazard detection. A reservation and
// a write-back clear landing on the same register in one cycle leave the bit set.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = REG_N
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      set_valid,
  input  reg_addr_t set_addr,
  input  logic      clr_valid,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rd_addr1,
  input  reg_addr_t rd_addr2,
  output logic      stall
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;

  // Clear first, then OR in the set so a same-register collision keeps the bit
  always_comb begin
    set_mask_s = {{(NREG-1){1'b0}}, set_valid} << set_addr;
    clr_mask_s = {{(NREG-1){1'b0}}, clr_valid} << clr_addr;
    pending_d  = (pending_q & ~clr_mask_s) | set_mask_s;
  end

  // Pending state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= {NREG{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  assign stall = pending_q[rd_addr1] | pending_q[rd_addr2];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter between ALU (A) and load (B) writeback for the single register-file
// write port, with registered strobes. Define REGFILE_ARB_SCOREBOARD_EN to add the pending scoreboard.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREG = REG_N,
  parameter int DW   = REG_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_arbiter_if.slave bus
);

  wb_req_t       req_a_s;
  wb_req_t       req_b_s;
  wb_req_t       win_s;
  logic          gnt_a_s;
  logic          gnt_b_s;

  logic          last_b_q;
  logic          last_b_d;
  logic          we_q;
  logic          we_d;
  reg_addr_t     waddr_q;
  reg_addr_t     waddr_d;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] wdata_d;

  assign req_a_s = '{valid: bus.req_a, addr: bus.addr_a, data: bus.data_a};
  assign req_b_s = '{valid: bus.req_b, addr: bus.addr_b, data: bus.data_b};

  // Round-robin grant: a lone requester wins, on contention the one not served last wins
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    case ({req_a_s.valid, req_b_s.valid})
      2'b10: gnt_a_s = 1'b1;
      2'b01: gnt_b_s = 1'b1;
      2'b11: begin
        gnt_a_s = last_b_q;
        gnt_b_s = ~last_b_q;
      end
      default: begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
      end
    endcase
  end

  // Grants are masked during reset so a transfer in flight at reset is dropped
  assign bus.gnt_a = gnt_a_s & ~rst;
  assign bus.gnt_b = gnt_b_s & ~rst;

  // Winner mux and next-state for the write port and priority pointer
  always_comb begin
    win_s = gnt_b_s ? req_b_s : req_a_s;
    we_d  = gnt_a_s | gnt_b_s;
    if (we_d) begin
      waddr_d  = win_s.addr;
      wdata_d  = win_s.data;
      last_b_d = gnt_b_s;
    end else begin
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      last_b_d = last_b_q;
    end
  end

  // Write-port strobe and pointer registers; pointer resets to B so A wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      last_b_q <= last_b_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.write_enable  = we_q;
  assign bus.write_address = waddr_q;
  assign bus.data_in       = wdata_q;

`ifdef REGFILE_ARB_SCOREBOARD_EN
  // The pending bit clears on the same edge the file commits the strobed write
  regfile_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (bus.reserve_valid),
    .set_addr  (bus.reserve_addr),
    .clr_valid (we_q),
    .clr_addr  (waddr_q),
    .rd_addr1  (bus.read_address1),
    .rd_addr2  (bus.read_address2),
    .stall     (bus.stall)
  );
`else
  localparam int unused_nreg_p = NREG;
  logic unused_sb_inputs_s;
  assign unused_sb_inputs_s = ^{bus.reserve_valid, bus.reserve_addr,
                                bus.read_address1, bus.read_address2};
  assign bus.stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: the driver predicts grants/stall and queues expected strobes;
// a monitor pops and compares every write-port strobe one cycle after its grant.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DW(REG_DW)) bus ();

  regfile_write_arbiter #(.NREG(REG_N), .DW(REG_DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    reg_addr_t addr;
    reg_data_t data;
  } wr_t;

  wr_t       exp_q[$];
  wr_t       mon_e;
  bit        pend_m [REG_N];
  bit        last_b_m;
  bit        prev_v_m;
  reg_addr_t prev_a_m;
  int        n_checks = 0;
  int        n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    last_b_m = 1'b1;
    prev_v_m = 1'b0;
    prev_a_m = '0;
  endtask

  task automatic idle_inputs();
    bus.req_a = 1'b0; bus.addr_a = '0; bus.data_a = '0;
    bus.req_b = 1'b0; bus.addr_b = '0; bus.data_b = '0;
    bus.reserve_valid = 1'b0; bus.reserve_addr = '0;
    bus.read_address1 = '0; bus.read_address2 = '0;
  endtask

  // One clock of stimulus; the reference model follows the rules at request level
  task automatic cycle(input bit ra, input reg_addr_t aa, input reg_data_t da,
                       input bit rb, input reg_addr_t ab, input reg_data_t db,
                       input bit rv, input reg_addr_t rva,
                       input reg_addr_t r1, input reg_addr_t r2,
                       output bit ga, output bit gb);
    bit ega, egb, est;
    @(negedge clk);
    bus.req_a = ra; bus.addr_a = aa; bus.data_a = da;
    bus.req_b = rb; bus.addr_b = ab; bus.data_b = db;
    bus.reserve_valid = rv; bus.reserve_addr = rva;
    bus.read_address1 = r1; bus.read_address2 = r2;
    #2;
    ega = ra && (!rb || last_b_m);
    egb = rb && (!ra || !last_b_m);
    chk("gnt_a", bus.gnt_a, ega);
    chk("gnt_b", bus.gnt_b, egb);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    est = pend_m[r1] | pend_m[r2];
`else
    est = 1'b0;
`endif
    chk("stall", bus.stall, est);
    if (prev_v_m) pend_m[prev_a_m] = 1'b0;
    if (rv) pend_m[rva] = 1'b1;
    prev_v_m = ega | egb;
    if (ega) begin
      exp_q.push_back('{aa, da});
      prev_a_m = aa;
      last_b_m = 1'b0;
    end else if (egb) begin
      exp_q.push_back('{ab, db});
      prev_a_m = ab;
      last_b_m = 1'b1;
    end
    ga = ega;
    gb = egb;
  endtask

  task automatic idle_cycle(input reg_addr_t r1, input reg_addr_t r2);
    bit ga, gb;
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, r1, r2, ga, gb);
  endtask

  // Monitor: every strobe must match the oldest grant, exactly one cycle later
  always @(posedge clk) begin
    #1;
    if (bus.write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe to %0d expected none", bus.write_address);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_address", bus.write_address, mon_e.addr);
        chk("data_in", bus.data_in, mon_e.data);
      end
    end else if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_strobe: got write_enable 0 expected strobe to %0d", mon_e.addr);
    end
  end

  initial begin
    bit        ga, gb;
    bit [3:0]  seq;
    bit        ha, hb;
    reg_addr_t haa, hab;
    reg_data_t hda, hdb;

    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    bus.req_a = 1'b1;
    #2;
    chk("rst_gnt_a", bus.gnt_a, 1'b0);
    chk("rst_write_enable", bus.write_enable, 1'b0);
    chk("rst_write_address", bus.write_address, 5'd0);
    chk("rst_data_in", bus.data_in, 32'd0);
    chk("rst_stall", bus.stall, 1'b0);
    bus.req_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Contention straight after reset: A, B, A, B
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 5'd1, 32'hA000_0000 + k, 1'b1, 5'd2, 32'hB000_0000 + k,
            1'b0, '0, '0, '0, ga, gb);
      seq[k] = ga;
    end
    chk("contention_order", seq, 4'b0101);

    // Single A write, then the port idles and holds its last address/data
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0, '0, '0, ga, gb);
    chk("single_a_gnt", ga, 1'b1);
    idle_cycle('0, '0);
    idle_cycle('0, '0);
    chk("hold_write_address", bus.write_address, 5'd5);
    chk("hold_data_in", bus.data_in, 32'hDEAD_BEEF);

    // Hazard on r7 resolved by a B write; also r9 reserved and read
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, '0, '0, ga, gb);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd7, 5'd9, ga, gb);
    cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h7777_0007, 1'b0, '0, 5'd7, 5'd9, ga, gb);
    idle_cycle(5'd7, '0);
    idle_cycle(5'd7, '0);
    idle_cycle(5'd9, 5'd9);

    // Reservation of r3 colliding with the strobe that clears r3
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3, '0, '0, ga, gb);
    cycle(1'b0, '0, '0, 1'b1, 5'd3, 32'h3333_0003, 1'b0, '0, '0, 5'd3, ga, gb);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3, '0, 5'd3, ga, gb);
    idle_cycle('0, 5'd3);
    idle_cycle('0, 5'd0);

    // Reset while A is being granted: no strobe, then A wins first again
    @(negedge clk);
    bus.req_a = 1'b1; bus.addr_a = 5'd4; bus.data_a = 32'h4444_0004;
    #2;
    chk("pre_reset_gnt_a", bus.gnt_a, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_gnt_a", bus.gnt_a, 1'b0);
    chk("midrst_write_address", bus.write_address, 5'd0);
    chk("midrst_stall", bus.stall, 1'b0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    chk("midrst_write_enable", bus.write_enable, 1'b0);
    cycle(1'b1, 5'd1, 32'h1111_0001, 1'b1, 5'd2, 32'h2222_0002, 1'b0, '0, '0, '0, ga, gb);
    chk("post_reset_a_first", ga, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 5'd2, 32'h2222_0002, 1'b0, '0, '0, '0, ga, gb);

    // Random traffic; each requester holds its request until granted
    ha = 1'b0; hb = 1'b0;
    haa = '0; hab = '0; hda = '0; hdb = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ha && ($urandom_range(0, 1) == 1)) begin
        ha = 1'b1; haa = reg_addr_t'($urandom_range(0, 7)); hda = $urandom;
      end
      if (!hb && ($urandom_range(0, 1) == 1)) begin
        hb = 1'b1; hab = reg_addr_t'($urandom_range(0, 7)); hdb = $urandom;
      end
      cycle(ha, haa, hda, hb, hab, hdb,
            ($urandom_range(0, 2) == 0), reg_addr_t'($urandom_range(0, 7)),
            reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7)),
            ga, gb);
      if (ga) ha = 1'b0;
      if (gb) hb = 1'b0;
    end

    idle_cycle('0, '0);
    idle_cycle('0, '0);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
